cache_mem_ctrl: RTL



---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_array.sv | 79 +++++++
 rtl/cache_mem_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding, widths and address field positions
package cache_pkg;

  typedef enum logic [1:0] {IDLE, D_WB, D_FILL, I_FILL} state_t;

  localparam int LINE_W  = 64;
  localparam int WORD_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int OFF_W   = 2;
  localparam int IDX_LSB = OFF_W;

  // Word k of a line occupies bits [16k+15:16k].
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_W-1:0]  off);
    return line[{off, 4'b0000} +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_array.sv
// rtl/cache_array.sv - direct-mapped tag/valid/data store with optional dirty bits
module cache_array
  import cache_pkg::*;
#(
  parameter int SETS      = 8,
  parameter int TAG_W     = 11,
  parameter bit HAS_DIRTY = 1'b0,
  localparam int IDX_W    = $clog2(SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              hit,
  output logic [LINE_W-1:0] rd_line,
  output logic [TAG_W-1:0]  stored_tag,
  output logic              victim_dirty,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              inv_en,
  input  logic [IDX_W-1:0]  inv_idx,
  input  logic [TAG_W-1:0]  inv_tag
);

  logic [TAG_W-1:0]  tags  [SETS];
  logic [LINE_W-1:0] lines [SETS];
  logic [SETS-1:0]   valid;

  assign hit        = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rd_line    = lines[rd_idx];
  assign stored_tag = tags[rd_idx];

  // A fill on the same edge as an invalidate of that set leaves the new line valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (inv_en && valid[inv_idx] && (tags[inv_idx] == inv_tag))
        valid[inv_idx] <= 1'b0;
      if (fill_en)
        valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fill_idx]  <= fill_tag;
      lines[fill_idx] <= fill_line;
    end else if (wr_en) begin
      lines[wr_idx][{wr_off, 4'b0000} +: WORD_W] <= wr_word;
    end
  end

  generate
    if (HAS_DIRTY) begin : g_dirty
      logic [SETS-1:0] dirty;

      always_ff @(posedge clk) begin
        if (rst)
          dirty <= '0;
        else if (fill_en)
          dirty[fill_idx] <= 1'b0;
        else if (wr_en)
          dirty[wr_idx] <= 1'b1;
      end

      assign victim_dirty = valid[rd_idx] & dirty[rd_idx];
    end else begin : g_clean
      assign victim_dirty = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/cache_mem_ctrl.sv
// rtl/cache_mem_ctrl.sv - split I/D cache responder with shared line-wide memory port
module cache_mem_ctrl
  import cache_pkg::*;
#(
  parameter int SETS  = 8,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 16 - 2 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic [15:0] d_addr,
  input  logic [15:0] wr_data,
  input  logic        mem_rd,
  input  logic        mem_wr,
  output logic [15:0] instr,
  output logic [15:0] data,
  output logic        i_rdy,
  output logic        d_rdy,
  output logic [13:0] m_addr,
  output logic        m_re,
  output logic        m_we,
  output logic [63:0] m_wdata,
  input  logic [63:0] m_rdata,
  input  logic        m_rdy
);

  localparam int TAG_LSB = IDX_LSB + IDX_W;

  state_t state, state_nx;

  logic [TAG_W-1:0]  i_tag, d_tag, d_vtag, i_tag_unused;
  logic [IDX_W-1:0]  i_idx, d_idx;
  logic [LINE_W-1:0] i_line, d_line;
  logic              i_hit, d_hit, d_vdirty, i_dirty_unused;
  logic              d_req, d_miss, idle, store_en, d_fill, i_fill;

  assign i_idx = i_addr[IDX_LSB +: IDX_W];
  assign d_idx = d_addr[IDX_LSB +: IDX_W];
  assign i_tag = i_addr[ADDR_W-1:TAG_LSB];
  assign d_tag = d_addr[ADDR_W-1:TAG_LSB];

  assign idle   = (state == IDLE);
  assign d_req  = mem_rd | mem_wr;
  assign d_miss = d_req & ~d_hit;

  // The I side yields to a pending D-miss: the MEM-stage instruction is older.
  assign i_rdy = i_hit & idle & ~d_miss;
  assign d_rdy = ~d_req | (d_hit & idle);

  assign instr = line_word(i_line, i_addr[OFF_W-1:0]);
  assign data  = line_word(d_line, d_addr[OFF_W-1:0]);

  // mem_wr wins when both request strobes are high.
  assign store_en = mem_wr & d_hit & idle;
  assign d_fill   = (state == D_FILL) & m_rdy;
  assign i_fill   = (state == I_FILL) & m_rdy;

  cache_array #(.SETS(SETS), .TAG_W(TAG_W), .HAS_DIRTY(1'b0)) u_icache (
    .clk          (clk),
    .rst          (rst),
    .rd_idx       (i_idx),
    .rd_tag       (i_tag),
    .hit          (i_hit),
    .rd_line      (i_line),
    .stored_tag   (i_tag_unused),
    .victim_dirty (i_dirty_unused),
    .fill_en      (i_fill),
    .fill_idx     (i_idx),
    .fill_tag     (i_tag),
    .fill_line    (m_rdata),
    .wr_en        (1'b0),
    .wr_idx       ('0),
    .wr_off       ('0),
    .wr_word      ('0),
    .inv_en       (store_en),
    .inv_idx      (d_idx),
    .inv_tag      (d_tag)
  );

  cache_array #(.SETS(SETS), .TAG_W(TAG_W), .HAS_DIRTY(1'b1)) u_dcache (
    .clk          (clk),
    .rst          (rst),
    .rd_idx       (d_idx),
    .rd_tag       (d_tag),
    .hit          (d_hit),
    .rd_line      (d_line),
    .stored_tag   (d_vtag),
    .victim_dirty (d_vdirty),
    .fill_en      (d_fill),
    .fill_idx     (d_idx),
    .fill_tag     (d_tag),
    .fill_line    (m_rdata),
    .wr_en        (store_en),
    .wr_idx       (d_idx),
    .wr_off       (d_addr[OFF_W-1:0]),
    .wr_word      (wr_data),
    .inv_en       (1'b0),
    .inv_idx      ('0),
    .inv_tag      ('0)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Memory-side outputs decode from the registered state, so they drop the cycle after reset.
  always_comb begin
    state_nx = state;
    m_re     = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    case (state)
      IDLE: begin
        if (d_miss)
          state_nx = d_vdirty ? D_WB : D_FILL;
        else if (!i_hit)
          state_nx = I_FILL;
      end
      D_WB: begin
        m_we    = 1'b1;
        m_addr  = {d_vtag, d_idx};
        m_wdata = d_line;
        if (m_rdy)
          state_nx = D_FILL;
      end
      D_FILL: begin
        m_re   = 1'b1;
        m_addr = {d_tag, d_idx};
        if (m_rdy)
          state_nx = IDLE;
      end
      I_FILL: begin
        m_re   = 1'b1;
        m_addr = {i_tag, i_idx};
        if (m_rdy)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
